// File: rtl/test_rtl_dma_xform_pkg.sv
// rtl/test_rtl_dma_xform_pkg.sv - shared states, transform modes and DMA size encodings
package test_rtl_dma_xform_pkg;

    typedef enum logic [3:0] {
        ST_IDLE    = 4'd0,
        ST_RD_REQ  = 4'd1,
        ST_RD_DATA = 4'd2,
        ST_WR_REQ  = 4'd3,
        ST_WR_DATA = 4'd4,
        ST_DONE    = 4'd5
    } state_t;

    localparam logic [1:0] MODE_COPY = 2'd0;
    localparam logic [1:0] MODE_ADD  = 2'd1;
    localparam logic [1:0] MODE_XOR  = 2'd2;
    localparam logic [1:0] MODE_INV  = 2'd3;

    localparam logic [2:0] DMA_SIZE_W32 = 3'b010;
    localparam logic [2:0] DMA_SIZE_W64 = 3'b011;

endpackage

// File: rtl/dma_chunk_buf.sv
// rtl/dma_chunk_buf.sv - staging buffer for one DMA chunk with fill/drain pointers and beat counts
module dma_chunk_buf #(
    parameter int DATA_W = 32,
    parameter int CHUNK  = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      clear,
    input  logic                      wr_en,
    input  logic [DATA_W-1:0]         wr_data,
    input  logic                      rd_adv,
    output logic [DATA_W-1:0]         rd_data,
    output logic [$clog2(CHUNK):0]    wr_cnt,
    output logic [$clog2(CHUNK):0]    rd_cnt
);

    logic [DATA_W-1:0]          mem [CHUNK];
    logic [$clog2(CHUNK)-1:0]   wr_ptr;
    logic [$clog2(CHUNK)-1:0]   rd_ptr;

    // Fill from the read channel, drain to the write channel; clear rewinds for the next chunk
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < CHUNK; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            wr_cnt <= '0;
            rd_cnt <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            wr_cnt <= '0;
            rd_cnt <= '0;
        end else begin
            if (wr_en) begin
                mem[wr_ptr] <= wr_data;
                wr_ptr      <= wr_ptr + 1'b1;
                wr_cnt      <= wr_cnt + 1'b1;
            end
            if (rd_adv) begin
                rd_ptr <= rd_ptr + 1'b1;
                rd_cnt <= rd_cnt + 1'b1;
            end
        end
    end

    assign rd_data = mem[rd_ptr];

endmodule

// File: rtl/test_rtl_dma_xform.sv
// rtl/test_rtl_dma_xform.sv - chunked DMA read, per-word transform, write-back accelerator
module test_rtl_dma_xform
    import test_rtl_dma_xform_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int CHUNK  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       conf_info_reg0,
    input  logic [31:0]       conf_info_reg1,
    input  logic [31:0]       conf_info_reg2,
    input  logic              conf_done,
    output logic              acc_done,
    output logic [31:0]       debug,
    output logic              dma_read_ctrl_valid,
    input  logic              dma_read_ctrl_ready,
    output logic [31:0]       dma_read_ctrl_data_index,
    output logic [31:0]       dma_read_ctrl_data_length,
    output logic [2:0]        dma_read_ctrl_data_size,
    output logic [4:0]        dma_read_ctrl_data_user,
    input  logic              dma_read_chnl_valid,
    output logic              dma_read_chnl_ready,
    input  logic [DATA_W-1:0] dma_read_chnl_data,
    output logic              dma_write_ctrl_valid,
    input  logic              dma_write_ctrl_ready,
    output logic [31:0]       dma_write_ctrl_data_index,
    output logic [31:0]       dma_write_ctrl_data_length,
    output logic [2:0]        dma_write_ctrl_data_size,
    output logic [4:0]        dma_write_ctrl_data_user,
    output logic              dma_write_chnl_valid,
    input  logic              dma_write_chnl_ready,
    output logic [DATA_W-1:0] dma_write_chnl_data
);

    localparam int         CW       = $clog2(CHUNK) + 1;
    localparam logic [2:0] SIZE_ENC = (DATA_W == 64) ? DMA_SIZE_W64 : DMA_SIZE_W32;

    state_t              state;
    state_t              state_nx;
    logic [31:0]         length_r;
    logic [31:0]         offset_r;
    logic [1:0]          mode_r;
    logic [DATA_W-1:0]   op_r;
    logic [15:0]         chunks_r;
    logic [31:0]         remain;
    logic [31:0]         clen;
    logic [DATA_W-1:0]   xf_data;
    logic [DATA_W-1:0]   buf_rd_data;
    logic [CW-1:0]       wr_cnt;
    logic [CW-1:0]       rd_cnt;
    logic                rd_beat;
    logic                wr_beat;
    logic                rd_last;
    logic                wr_last;
    logic                unused_conf;

    assign unused_conf = ^conf_info_reg1[31:2];

    assign remain  = length_r - offset_r;
    assign clen    = (remain > 32'(CHUNK)) ? 32'(CHUNK) : remain;
    assign rd_beat = dma_read_chnl_valid && dma_read_chnl_ready;
    assign wr_beat = dma_write_chnl_valid && dma_write_chnl_ready;
    assign rd_last = rd_beat && (32'(wr_cnt) + 32'd1 == clen);
    assign wr_last = wr_beat && (32'(rd_cnt) + 32'd1 == clen);

    assign dma_read_chnl_ready      = (state == ST_RD_DATA);
    assign dma_write_chnl_data      = dma_write_chnl_valid ? buf_rd_data : '0;
    assign dma_read_ctrl_data_user  = 5'd0;
    assign dma_write_ctrl_data_user = 5'd0;
    assign debug                    = {chunks_r, 12'd0, state};

    // Per-word transform applied to the incoming read beat
    always_comb begin
        xf_data = dma_read_chnl_data;
        case (mode_r)
            MODE_ADD: xf_data = dma_read_chnl_data + op_r;
            MODE_XOR: xf_data = dma_read_chnl_data ^ op_r;
            MODE_INV: xf_data = ~dma_read_chnl_data;
            default:  xf_data = dma_read_chnl_data;
        endcase
    end

    dma_chunk_buf #(
        .DATA_W (DATA_W),
        .CHUNK  (CHUNK)
    ) u_buf (
        .clk     (clk),
        .rst     (rst),
        .clear   (state == ST_RD_REQ),
        .wr_en   (rd_beat),
        .wr_data (xf_data),
        .rd_adv  (wr_beat),
        .rd_data (buf_rd_data),
        .wr_cnt  (wr_cnt),
        .rd_cnt  (rd_cnt)
    );

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state: read a chunk, write it back, repeat until the whole length is covered
    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE: begin
                if (conf_done) begin
                    if (conf_info_reg0 == 32'd0) state_nx = ST_DONE;
                    else                         state_nx = ST_RD_REQ;
                end
            end
            ST_RD_REQ:  if (dma_read_ctrl_valid && dma_read_ctrl_ready) state_nx = ST_RD_DATA;
            ST_RD_DATA: if (rd_last) state_nx = ST_WR_REQ;
            ST_WR_REQ:  if (dma_write_ctrl_valid && dma_write_ctrl_ready) state_nx = ST_WR_DATA;
            ST_WR_DATA: begin
                if (wr_last) begin
                    if (offset_r + clen == length_r) state_nx = ST_DONE;
                    else                             state_nx = ST_RD_REQ;
                end
            end
            ST_DONE:    state_nx = ST_IDLE;
            default:    state_nx = ST_IDLE;
        endcase
    end

    // Config latches, progress counters and the completion pulse
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            length_r <= '0;
            offset_r <= '0;
            mode_r   <= MODE_COPY;
            op_r     <= '0;
            chunks_r <= '0;
            acc_done <= 1'b0;
        end else begin
            acc_done <= (state == ST_DONE);
            if (state == ST_IDLE && conf_done) begin
                length_r <= conf_info_reg0;
                mode_r   <= conf_info_reg1[1:0];
                op_r     <= DATA_W'(conf_info_reg2);
                offset_r <= '0;
                chunks_r <= '0;
            end else if (wr_last) begin
                offset_r <= offset_r + clen;
                chunks_r <= chunks_r + 16'd1;
            end
        end
    end

    // Ctrl requests rise one cycle into their REQ state and drop on handshake
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dma_read_ctrl_valid        <= 1'b0;
            dma_read_ctrl_data_index   <= '0;
            dma_read_ctrl_data_length  <= '0;
            dma_read_ctrl_data_size    <= '0;
            dma_write_ctrl_valid       <= 1'b0;
            dma_write_ctrl_data_index  <= '0;
            dma_write_ctrl_data_length <= '0;
            dma_write_ctrl_data_size   <= '0;
        end else begin
            if (state == ST_RD_REQ && !(dma_read_ctrl_valid && dma_read_ctrl_ready)) begin
                dma_read_ctrl_valid       <= 1'b1;
                dma_read_ctrl_data_index  <= offset_r;
                dma_read_ctrl_data_length <= clen;
                dma_read_ctrl_data_size   <= SIZE_ENC;
            end else begin
                dma_read_ctrl_valid <= 1'b0;
            end
            if (state == ST_WR_REQ && !(dma_write_ctrl_valid && dma_write_ctrl_ready)) begin
                dma_write_ctrl_valid       <= 1'b1;
                dma_write_ctrl_data_index  <= length_r + offset_r;
                dma_write_ctrl_data_length <= clen;
                dma_write_ctrl_data_size   <= SIZE_ENC;
            end else begin
                dma_write_ctrl_valid <= 1'b0;
            end
        end
    end

    // Write channel valid follows WR_DATA by one cycle and drops after the final beat
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dma_write_chnl_valid <= 1'b0;
        end else begin
            dma_write_chnl_valid <= (state == ST_WR_DATA) && !wr_last;
        end
    end

endmodule
